// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default widths and a constant-width helper.
package uart_tx_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_SEND  = 2'b11,
        ST_WAIT  = 2'b10
    } state_t;

    // Bits needed to index 'value' items; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client/transmitter-side signal bundle of the UART transmit arbiter.
// slave: the arbiter's view; master: the environment (clients + transmitter).
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int unsigned IW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_send;
    logic                          tx_busy;
    logic [IW-1:0]                 active_id;
    logic                          tx_active;
    logic                          tx_err;

    modport slave (
        input  req, req_data, tx_busy,
        output ack, tx_data, tx_send, active_id, tx_active, tx_err
    );

    modport master (
        output req, req_data, tx_busy,
        input  ack, tx_data, tx_send, active_id, tx_active, tx_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first set request bit searching upward from ptr+1,
// wrapping, so the previous winner has lowest priority.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    localparam int unsigned IW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    // Rotating priority search starting just after the last winner
    always_comb begin
        int unsigned idx;
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && req[IW'(idx)]) begin
                any_req = 1'b1;
                winner  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers, round-robin.
// Latches the winner's byte, raises send until the transmitter reports busy,
// then waits for busy to fall before the next grant. Aborts with tx_err if
// busy never rises within BUSY_TIMEOUT cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned BUSY_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned IW = clog2(NUM_REQ);
    localparam int unsigned CW = clog2(BUSY_TIMEOUT) + 1;

    state_t                state;
    state_t                state_nxt;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         win_q;
    logic [IW-1:0]         pick;
    logic                  any_req;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [IW-1:0]         id_q;
    logic                  err_q;
    logic                  abort;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .winner  (pick),
        .any_req (any_req)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort flags a SEND that never saw busy
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (bus.tx_busy) begin
                    state_nxt = ST_WAIT;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte of the granted requester
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_q == IW'(i)) begin
                sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Winner capture, data latch, rr pointer, timeout counter and error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= IW'(NUM_REQ - 1);
            win_q  <= '0;
            cnt    <= '0;
            data_q <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= abort;
            if (state == ST_IDLE && any_req) begin
                win_q <= pick;
            end
            if (state == ST_GRANT) begin
                data_q <= sel_data;
                id_q   <= win_q;
                ptr    <= win_q;
                cnt    <= '0;
            end else if (state == ST_SEND && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // State-decoded handshake outputs
    always_comb begin
        bus.ack = '0;
        if (state == ST_GRANT) begin
            bus.ack[win_q] = 1'b1;
        end
        bus.tx_send   = (state == ST_SEND);
        bus.tx_active = (state != ST_IDLE);
    end

    assign bus.tx_data   = data_q;
    assign bus.active_id = id_q;
    assign bus.tx_err    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter model, grant scoreboard,
// table of single-requester frames plus arbitration/timeout/reset sequences.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- transmitter model ----------------
    // busy becomes visible in the k-th cycle of send, then stays 20 cycles.
    int   k_cfg     = 3;
    bit   never     = 1'b0;
    logic hold_busy = 1'b0;
    logic m_busy    = 1'b0;
    int   seen      = 0;
    int   left      = 0;

    assign bus.tx_busy = m_busy | hold_busy;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            seen = 0;
            left = 0;
        end else if (m_busy) begin
            left--;
            if (left == 0) m_busy <= 1'b0;
        end else if (bus.tx_send && !never) begin
            seen++;
            if (seen >= k_cfg - 1) begin
                m_busy <= 1'b1;
                left = 20;
                seen = 0;
            end
        end else begin
            seen = 0;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic prev_send = 1'b0;
    int   send_len = 0;
    int   last_send_len = 0;
    int   frames = 0;
    int   err_cycles = 0;

    always @(negedge clk) begin
        if (bus.ack != '0) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'(bus.ack), 32'd0);
            end else begin
                cur = sb.pop_front();
                check("ack_onehot", 32'(bus.ack), 32'd1 << cur.id);
            end
        end
        if (bus.tx_send && !prev_send) begin
            check("tx_data_at_send", 32'(bus.tx_data), 32'(cur.data));
            check("active_id_at_send", 32'(bus.active_id), 32'(cur.id));
        end
        if (bus.tx_send) begin
            send_len++;
        end else if (prev_send) begin
            last_send_len = send_len;
            send_len = 0;
            frames++;
        end
        if (bus.tx_err) err_cycles++;
        prev_send = bus.tx_send;
    end

    // ---------------- helpers ----------------
    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string tag, output int id, output int lat);
        id  = -1;
        lat = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                lat = c;
                for (int i = 0; i < int'(NR); i++) if (bus.ack[i]) id = i;
                return;
            end
        end
        check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!bus.tx_active) begin
                #1;
                return;
            end
        end
        check({tag, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    typedef struct {
        int         id;
        logic [7:0] data;
        int         k;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int id, lat, f0, e0;
        int order[5];

        vecs[0] = '{0, 8'hA5, 3};
        vecs[1] = '{1, 8'h3C, 2};
        vecs[2] = '{2, 8'h00, 5};
        vecs[3] = '{3, 8'hFF, 4};
        order   = '{0, 1, 2, 3, 0};

        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (2) @(negedge clk);
        check("rst_ack",       32'(bus.ack),       32'd0);
        check("rst_tx_data",   32'(bus.tx_data),   32'd0);
        check("rst_tx_send",   32'(bus.tx_send),   32'd0);
        check("rst_active_id", 32'(bus.active_id), 32'd0);
        check("rst_tx_active", 32'(bus.tx_active), 32'd0);
        check("rst_tx_err",    32'(bus.tx_err),    32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table: single requester frames
        for (int v = 0; v < 4; v++) begin
            k_cfg = vecs[v].k;
            bus.req_data[vecs[v].id*DW +: DW] = vecs[v].data;
            push(vecs[v].id, vecs[v].data);
            f0 = frames;
            bus.req = 4'b0001 << vecs[v].id;
            wait_ack("tbl", id, lat);
            check("tbl_ack_latency", 32'(lat), 32'd0);
            bus.req = '0;
            @(negedge clk);
            check("tbl_send_after_ack", 32'(bus.tx_send), 32'd1);
            wait_idle("tbl");
            check("tbl_send_len", 32'(last_send_len), 32'(vecs[v].k));
            check("tbl_frames", 32'(frames - f0), 32'd1);
            check("tbl_data_held", 32'(bus.tx_data), 32'(vecs[v].data));
        end

        // All four held: strict rotation 0,1,2,3,0
        k_cfg = 3;
        for (int i = 0; i < 4; i++) bus.req_data[i*DW +: DW] = 8'h10 + 8'(i);
        for (int i = 0; i < 5; i++) push(order[i], 8'h10 + 8'(order[i]));
        f0 = frames;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack("rr", id, lat);
            check("rr_order", 32'(id), 32'(order[i]));
            if (i == 4) bus.req = '0;
        end
        wait_idle("rr");
        check("rr_frames", 32'(frames - f0), 32'd5);

        // Wrap: after serving 2, 0101 grants 0 then 2
        bus.req_data[0*DW +: DW] = 8'h55;
        bus.req_data[2*DW +: DW] = 8'h77;
        push(2, 8'h77);
        bus.req = 4'b0100;
        wait_ack("wrap_pre", id, lat);
        bus.req = '0;
        wait_idle("wrap_pre");
        push(0, 8'h55);
        push(2, 8'h77);
        bus.req = 4'b0101;
        wait_ack("wrap", id, lat);
        check("wrap_first", 32'(id), 32'd0);
        bus.req[0] = 1'b0;
        wait_ack("wrap", id, lat);
        check("wrap_second", 32'(id), 32'd2);
        bus.req = '0;
        wait_idle("wrap");

        // Timeout: busy never rises; 16 send cycles, tx_err, then next requester
        never = 1'b1;
        bus.req_data[1*DW +: DW] = 8'h99;
        bus.req_data[2*DW +: DW] = 8'h42;
        push(1, 8'h99);
        push(2, 8'h42);
        e0 = err_cycles;
        bus.req = 4'b0110;
        wait_ack("to", id, lat);
        check("to_first", 32'(id), 32'd1);
        bus.req[1] = 1'b0;
        begin : find_err
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (bus.tx_err) begin
                    check("to_idle_on_err", 32'(bus.tx_active), 32'd0);
                    check("to_send_on_err", 32'(bus.tx_send), 32'd0);
                    #1;
                    check("to_send_len", 32'(last_send_len), TO);
                    disable find_err;
                end
            end
            check("to_err_timeout", 32'd0, 32'd1);
        end
        never = 1'b0;
        wait_ack("to", id, lat);
        check("to_next", 32'(id), 32'd2);
        bus.req = '0;
        wait_idle("to");
        check("to_err_width", 32'(err_cycles - e0), 32'd1);
        check("to_next_send_len", 32'(last_send_len), 32'(k_cfg));

        // Busy already high on SEND entry: one send cycle, WAIT until busy falls
        hold_busy = 1'b1;
        bus.req_data[3*DW +: DW] = 8'hC3;
        push(3, 8'hC3);
        bus.req = 4'b1000;
        wait_ack("bz", id, lat);
        bus.req = '0;
        repeat (8) @(negedge clk);
        check("bz_still_active", 32'(bus.tx_active), 32'd1);
        check("bz_no_send", 32'(bus.tx_send), 32'd0);
        check("bz_send_len", 32'(last_send_len), 32'd1);
        hold_busy = 1'b0;
        wait_idle("bz");

        // Reset in WAIT, then pointer restarts at requester 0
        bus.req_data[0*DW +: DW] = 8'h6E;
        push(0, 8'h6E);
        bus.req = 4'b0001;
        wait_ack("rs", id, lat);
        bus.req = '0;
        begin : find_wait
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (bus.tx_busy && !bus.tx_send && bus.tx_active) disable find_wait;
            end
            check("rs_wait_timeout", 32'd0, 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check("rs_ack",       32'(bus.ack),       32'd0);
        check("rs_tx_data",   32'(bus.tx_data),   32'd0);
        check("rs_tx_send",   32'(bus.tx_send),   32'd0);
        check("rs_active_id", 32'(bus.active_id), 32'd0);
        check("rs_tx_active", 32'(bus.tx_active), 32'd0);
        check("rs_tx_err",    32'(bus.tx_err),    32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_data[0*DW +: DW] = 8'h11;
        bus.req_data[1*DW +: DW] = 8'h22;
        push(0, 8'h11);
        push(1, 8'h22);
        bus.req = 4'b0011;
        wait_ack("rs", id, lat);
        check("rs_first_grant", 32'(id), 32'd0);
        bus.req[0] = 1'b0;
        wait_ack("rs", id, lat);
        check("rs_second_grant", 32'(id), 32'd1);
        bus.req = '0;
        wait_idle("rs");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
